elevator_ctrl: RTL and testbench

- Single-car scheduler directly downstream of the per-floor hall-call latches.
- Consumes each floor's 3-bit request word and in-car button pulses.
- Runs a collective up/down scan: tracks car position, times travel and door dwell, and returns per-floor off_request pulses that clear served hall calls.

---
 rtl/elevator_ctrl.sv | 158 +++++++++++++++
 tb/tb_elevator_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/elevator_ctrl.sv
// Single-car collective up/down scan scheduler: tracks car position, times travel
// and door dwell, and strobes per-floor clears back to the hall-call latches.
module elevator_ctrl #(
    parameter int NUM_FLOORS    = 8,
    parameter int FLOOR_W       = 3,
    parameter int TRAVEL_CYCLES = 16,
    parameter int DOOR_CYCLES   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3*NUM_FLOORS-1:0] floor_req,
    input  logic [NUM_FLOORS-1:0]   car_req,
    output logic [2*NUM_FLOORS-1:0] off_request,
    output logic [FLOOR_W-1:0]      cur_floor,
    output logic                    dir_up,
    output logic                    moving,
    output logic                    door_open,
    output logic [1:0]              state
);
    localparam int TW = $clog2(TRAVEL_CYCLES);
    localparam int DW = $clog2(DOOR_CYCLES);
    localparam logic [TW-1:0]      T_LAST = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0]      D_LAST = DW'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TOP    = FLOOR_W'(NUM_FLOORS - 1);

    typedef enum logic [1:0] {S_IDLE = 2'b00, S_MOVE = 2'b01, S_DOOR = 2'b10} state_t;

    state_t                  state_q;
    logic [FLOOR_W-1:0]      floor_q;
    logic                    dir_q, moving_q, door_q;
    logic [2*NUM_FLOORS-1:0] off_q;
    logic [NUM_FLOORS-1:0]   car_pend_q, car_pend_d;
    logic [TW-1:0]           tcnt_q;
    logic [DW-1:0]           dcnt_q;

    logic [NUM_FLOORS-1:0]   up_c, dn_c, hall_c, req_c, any_unused;
    logic [FLOOR_W-1:0]      nxt_floor, ent_floor;
    logic                    above, below, here, arrive, stop, go_door;
    logic                    ent_same, ent_opp, ent_dir;
    logic [2*NUM_FLOORS-1:0] ent_off;

    // True when r has a request strictly above (up=1) or below (up=0) floor g.
    function automatic logic beyond(input logic [NUM_FLOORS-1:0] r,
                                    input logic [FLOOR_W-1:0] g, input logic up);
        beyond = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (up ? (i > int'(g)) : (i < int'(g))) beyond = beyond | r[i];
    endfunction

    always_comb begin
        for (int f = 0; f < NUM_FLOORS; f++) begin
            up_c[f]       = floor_req[3*f+1];
            dn_c[f]       = floor_req[3*f];
            any_unused[f] = floor_req[3*f+2];
        end
    end

    assign hall_c    = up_c | dn_c;
    assign req_c     = hall_c | car_pend_q;
    assign nxt_floor = dir_q ? floor_q + 1'b1 : floor_q - 1'b1;
    assign above     = beyond(req_c, floor_q, 1'b1);
    assign below     = beyond(req_c, floor_q, 1'b0);
    assign here      = req_c[floor_q];
    assign arrive    = (state_q == S_MOVE) && (tcnt_q == T_LAST);

    // Stop decision is made on the arrival edge, against the floor being entered.
    assign stop = car_pend_q[nxt_floor]
                | (dir_q ? up_c[nxt_floor] : dn_c[nxt_floor])
                | (~beyond(req_c, nxt_floor, dir_q) & hall_c[nxt_floor])
                | (nxt_floor == '0) | (nxt_floor == TOP);

    assign go_door   = ((state_q == S_IDLE) && here) || (arrive && stop);
    assign ent_floor = (state_q == S_MOVE) ? nxt_floor : floor_q;
    assign ent_same  = dir_q ? up_c[ent_floor] : dn_c[ent_floor];
    assign ent_opp   = dir_q ? dn_c[ent_floor] : up_c[ent_floor];
    assign ent_dir   = dir_q ^ (~ent_same & ent_opp);

    always_comb begin
        ent_off = '0;
        for (int f = 0; f < NUM_FLOORS; f++)
            if (FLOOR_W'(f) == ent_floor && (ent_same || ent_opp))
                ent_off[2*f +: 2] = {1'b1, ent_same ? ~dir_q : dir_q};
    end

    // A button for the floor whose door is open only extends the dwell.
    always_comb begin
        car_pend_d = car_pend_q | car_req;
        if (state_q == S_DOOR) car_pend_d[floor_q] = car_pend_q[floor_q];
        if (go_door) car_pend_d[ent_floor] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            floor_q    <= '0;
            dir_q      <= 1'b1;
            moving_q   <= 1'b0;
            door_q     <= 1'b0;
            off_q      <= '0;
            car_pend_q <= '0;
            tcnt_q     <= '0;
            dcnt_q     <= '0;
        end else begin
            off_q      <= '0;
            car_pend_q <= car_pend_d;
            if (go_door) begin
                state_q  <= S_DOOR;
                floor_q  <= ent_floor;
                dir_q    <= ent_dir;
                off_q    <= ent_off;
                moving_q <= 1'b0;
                door_q   <= 1'b1;
                tcnt_q   <= '0;
                dcnt_q   <= D_LAST;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (above && (dir_q || !below)) begin
                            dir_q    <= 1'b1;
                            state_q  <= S_MOVE;
                            moving_q <= 1'b1;
                        end else if (below) begin
                            dir_q    <= 1'b0;
                            state_q  <= S_MOVE;
                            moving_q <= 1'b1;
                        end
                    end
                    S_MOVE: begin
                        if (arrive) begin
                            floor_q <= nxt_floor;
                            tcnt_q  <= '0;
                        end else begin
                            tcnt_q  <= tcnt_q + 1'b1;
                        end
                    end
                    S_DOOR: begin
                        if (car_req[floor_q]) begin
                            dcnt_q <= D_LAST;
                        end else if (dcnt_q == '0) begin
                            state_q <= S_IDLE;
                            door_q  <= 1'b0;
                        end else begin
                            dcnt_q <= dcnt_q - 1'b1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign off_request = off_q;
    assign cur_floor   = floor_q;
    assign dir_up      = dir_q;
    assign moving      = moving_q;
    assign door_open   = door_q;
    assign state       = state_q;
endmodule

// File: tb/tb_elevator_ctrl.sv
// Scoreboard bench for elevator_ctrl: a behavioural car model predicts the outputs
// for every clock; a monitor pops and compares them against the DUT.
module tb_elevator_ctrl;
    localparam int N  = 8;
    localparam int FW = 3;
    localparam int T  = 16;
    localparam int D  = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [3*N-1:0]  floor_req;
    logic [N-1:0]    car_req;
    logic [2*N-1:0]  off_request;
    logic [FW-1:0]   cur_floor;
    logic            dir_up, moving, door_open;
    logic [1:0]      state;

    elevator_ctrl #(.NUM_FLOORS(N), .FLOOR_W(FW), .TRAVEL_CYCLES(T), .DOOR_CYCLES(D)) dut (
        .clk(clk), .rst(rst), .floor_req(floor_req), .car_req(car_req),
        .off_request(off_request), .cur_floor(cur_floor), .dir_up(dir_up),
        .moving(moving), .door_open(door_open), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]     st;
        logic [FW-1:0]  fl;
        logic           dir;
        logic [2*N-1:0] off;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0, n_pass = 0;
    bit   armed = 0;

    // Hall-call latches emulating the floor block.
    logic [N-1:0]   hu, hd;
    logic [2*N-1:0] prev_off;

    // Car model: position, direction, remaining travel / dwell clocks.
    int             m_pos, m_tl, m_dw;
    bit             m_up;
    logic [N-1:0]   m_pend;
    logic [2*N-1:0] m_off;

    function automatic bit anyb(input logic [N-1:0] r, input int g, input bit upd);
        for (int i = 0; i < N; i++)
            if (r[i] && (upd ? (i > g) : (i < g))) return 1'b1;
        return 1'b0;
    endfunction

    task automatic enter(input int g);
        bit same, opp;
        same = m_up ? hu[g] : hd[g];
        opp  = m_up ? hd[g] : hu[g];
        if (same) begin
            m_off[2*g+1] = 1'b1;
            m_off[2*g]   = !m_up;
        end else if (opp) begin
            m_off[2*g+1] = 1'b1;
            m_off[2*g]   = m_up;
            m_up         = !m_up;
        end
        m_pend[g] = 1'b0;
        m_dw      = D;
    endtask

    task automatic model(input logic [N-1:0] cr, input bit rv);
        logic [N-1:0] old, r;
        if (!rv) begin
            m_pos = 0; m_up = 1'b1; m_tl = 0; m_dw = 0; m_pend = '0; m_off = '0;
            return;
        end
        old    = m_pend;
        r      = hu | hd | old;
        m_off  = '0;
        m_pend = old | cr;
        if (m_dw > 0) begin
            m_pend[m_pos] = old[m_pos];
            if (cr[m_pos]) m_dw = D;
            else m_dw--;
        end else if (m_tl > 0) begin
            m_tl--;
            if (m_tl == 0) begin
                m_pos += m_up ? 1 : -1;
                if (old[m_pos] || (m_up ? hu[m_pos] : hd[m_pos]) ||
                    (!anyb(r, m_pos, m_up) && (hu[m_pos] || hd[m_pos])) ||
                    m_pos == 0 || m_pos == N-1)
                    enter(m_pos);
                else
                    m_tl = T;
            end
        end else begin
            if (r[m_pos]) enter(m_pos);
            else if (anyb(r, m_pos, 1'b1) && (m_up || !anyb(r, m_pos, 1'b0))) begin
                m_up = 1'b1; m_tl = T;
            end else if (anyb(r, m_pos, 1'b0)) begin
                m_up = 1'b0; m_tl = T;
            end
        end
    endtask

    // One clock of stimulus: presses, car buttons and reset for the next edge.
    task automatic step(input logic [N-1:0] pu, input logic [N-1:0] pd,
                        input logic [N-1:0] cr, input bit rv);
        exp_t e;
        logic [N-1:0] cu, cd;
        @(negedge clk);
        for (int f = 0; f < N; f++) begin
            cu[f] = prev_off[2*f+1] & ~prev_off[2*f];
            cd[f] = prev_off[2*f+1] &  prev_off[2*f];
        end
        hu = (hu | pu) & ~cu;
        hd = (hd | pd) & ~cd;
        prev_off = m_off;
        for (int f = 0; f < N; f++) begin
            floor_req[3*f+1] = hu[f];
            floor_req[3*f]   = hd[f];
            floor_req[3*f+2] = 1'($urandom_range(0, 1));
        end
        car_req = cr;
        rst     = rv;
        model(cr, rv);
        e.st  = (m_dw > 0) ? 2'd2 : ((m_tl > 0) ? 2'd1 : 2'd0);
        e.fl  = FW'(m_pos);
        e.dir = m_up;
        e.off = m_off;
        exp_q.push_back(e);
        armed = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                if (armed) begin
                    n_chk++;
                    $display("FAIL scoreboard_empty t=%0t", $time);
                end
            end else begin
                e = exp_q.pop_front();
                n_chk++;
                if (state === e.st && cur_floor === e.fl && dir_up === e.dir &&
                    off_request === e.off && moving === (e.st == 2'd1) &&
                    door_open === (e.st == 2'd2))
                    n_pass++;
                else
                    $display("FAIL cycle_check t=%0t got st=%0d fl=%0d dir=%0b mv=%0b door=%0b off=%h expected st=%0d fl=%0d dir=%0b off=%h",
                             $time, state, cur_floor, dir_up, moving, door_open, off_request,
                             e.st, e.fl, e.dir, e.off);
            end
        end
    end

    initial begin : stim
        logic [N-1:0] pu, pd, cr;
        hu = '0; hd = '0; prev_off = '0; m_off = '0; m_pend = '0;
        m_pos = 0; m_up = 1'b1; m_tl = 0; m_dw = 0;
        floor_req = '0; car_req = '0; rst = 1'b0;

        repeat (10) step('0, '0, '0, 1'b0);
        repeat (2)  step('0, '0, '0, 1'b1);
        // up call at floor 3 from floor 0
        step(8'h08, '0, '0, 1'b1);
        repeat (150) step('0, '0, '0, 1'b1);
        // car button 5, then a down call at 2 that must be passed going up
        repeat (2) step('0, '0, '0, 1'b0);
        step('0, '0, 8'h20, 1'b1);
        repeat (20) step('0, '0, '0, 1'b1);
        step('0, 8'h04, '0, 1'b1);
        repeat (300) step('0, '0, '0, 1'b1);
        // both calls at floor 4
        step(8'h10, 8'h10, '0, 1'b1);
        repeat (250) step('0, '0, '0, 1'b1);
        // top floor with button re-pressed during dwell
        for (int i = 0; i < 250; i++)
            step('0, '0, (i == 0 || i == 60 || i == 75 || i == 90) ? 8'h80 : 8'h00, 1'b1);
        // reset in the middle of a move
        step('0, '0, 8'h01, 1'b1);
        repeat (23) step('0, '0, '0, 1'b1);
        step('0, '0, '0, 1'b0);
        repeat (5) step('0, '0, '0, 1'b1);
        // randomized traffic with occasional resets
        for (int c = 0; c < 6000; c++) begin
            for (int f = 0; f < N; f++) begin
                pu[f] = ($urandom_range(0, 199) == 0);
                pd[f] = ($urandom_range(0, 199) == 0);
                cr[f] = ($urandom_range(0, 299) == 0);
            end
            step(pu, pd, cr, !($urandom_range(0, 1499) == 0));
        end
        @(posedge clk);
        #2;
        n_chk++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_leftover got %0d entries expected 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
